uart_rx_fifo: RTL
=================

UART_RX_FIFO -- requirements
Module: uart_rx_fifo

Interface
REQ-001 Parameter CLKS_PER_BIT, default 868, clk_o cycles per serial bit (100 MHz / 115200); legal minimum 4.
REQ-002 Parameter FIFO_DEPTH, default 8, receive buffer entries; power of two, 2..64.
REQ-003 clk_o  input  1  block clock; all state SHALL update on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 rx_i  input  1  asynchronous serial line, idle high.
REQ-006 rd_en_i  input  1  pop request from the load/store unit.
REQ-007 clr_err_i  input  1  clears the sticky error flags.
REQ-008 rd_data_o  output  8  byte at the FIFO head, first-word fall-through.
REQ-009 rx_valid_o  output  1  FIFO not empty.
REQ-010 full_o  output  1  FIFO holds FIFO_DEPTH entries.
REQ-011 count_o  output  $clog2(FIFO_DEPTH)+1  current occupancy.
REQ-012 frame_err_o  output  1  sticky flag: a byte was discarded because its stop bit was sampled low.
REQ-013 overrun_o  output  1  sticky flag: a byte was discarded because the FIFO was full.
REQ-014 parity_err_o  output  1  sticky flag: a byte was discarded on parity mismatch; tied 0 when UART_RX_PARITY_EN is undefined.

Function
REQ-015 rx_i SHALL pass through a 2-flop synchronizer before any use; all latencies below are measured from the synchronized signal.
REQ-016 FSM states: IDLE, START, DATA, PARITY (compiled in only), STOP.
REQ-017 IDLE->START on a synchronized high-to-low transition; the baud counter resets to 0.
REQ-018 START: sample at count CLKS_PER_BIT/2-1; sampled 1 -> IDLE (glitch rejected, no flag); sampled 0 -> DATA.
REQ-019 DATA: sample every CLKS_PER_BIT cycles; 8 bits LSB first; a 3-bit index wraps 7->0 on exit to PARITY or STOP.
REQ-020 STOP: one sample CLKS_PER_BIT after the last data/parity sample, then return to IDLE.
REQ-021 On a stop bit of 1 with no parity error, push the byte in the same cycle; on a stop bit of 0, discard the byte and set frame_err_o.
REQ-022 FIFO: circular, read/write pointers one bit wider than the address; rd_data_o SHALL show the head combinationally from stored data.
REQ-023 Push while full: byte dropped, overrun_o set, contents unchanged; if rd_en_i is asserted in the same cycle, pop and push both succeed.
REQ-024 Pop while empty: ignored; pointers, count_o and flags unchanged.
REQ-025 Simultaneous push and pop on a non-empty FIFO: count_o unchanged, both pointers advance.
REQ-026 A byte is visible on rx_valid_o/rd_data_o the cycle after its push.
REQ-027 Sticky flags SHALL clear on clr_err_i; a same-cycle set takes priority over clear.
REQ-028 The receiver SHALL accept back-to-back frames; a start edge in the cycle after STOP SHALL be detected.

Reset
REQ-029 While reset is high: FSM=IDLE, counters=0, pointers=0, synchronizer flops=1, rd_data_o=0, rx_valid_o=0, full_o=0, count_o=0, all flags=0.
REQ-030 Reset mid-frame SHALL abandon the partial byte; the FIFO is emptied and no flag is set.

Configuration
REQ-031 UART_RX_PARITY_EN defined: even parity bit follows the data bits (PARITY state); a mismatch discards the byte and sets parity_err_o; frame length is 11 bits.
REQ-032 UART_RX_PARITY_EN undefined: no PARITY state, frame is 8N1, parity_err_o is constant 0.

Verification (CLKS_PER_BIT=4, FIFO_DEPTH=8)
REQ-033 Send 8N1 byte 0xA5 -> after the stop sample, rx_valid_o=1, rd_data_o=0xA5, count_o=1; one rd_en_i pulse -> count_o=0, rx_valid_o=0.
REQ-034 Send 0x3C with stop bit forced 0 -> count_o stays 0, frame_err_o=1; clr_err_i -> 0.
REQ-035 Send nine bytes 0x01..0x09 with no reads -> count_o=8, full_o=1, overrun_o=1; eight pops return 0x01..0x08.
REQ-036 Drive rx_i low for 1 clock in IDLE -> no push, no flag, FSM back in IDLE.
REQ-037 Assert reset during data bit 4 of 0xFF, then send 0x42 -> FIFO holds only 0x42.
REQ-038 With UART_RX_PARITY_EN defined, send 0x07 with parity bit 0 -> byte dropped, parity_err_o=1; with parity bit 1 -> 0x07 pushed.

Source files
------------

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: UART receiver (8N1, or 8E1 when UART_RX_PARITY_EN is defined)
// feeding a first-word fall-through receive FIFO.
//
// Optional feature macro: UART_RX_PARITY_EN adds an even parity bit after the data bits.
//
// Ports:
//   clk_o        in   block clock, rising edge
//   reset        in   synchronous active-high reset
//   rx_i         in   asynchronous serial line, idle high
//   rd_en_i      in   pop request
//   clr_err_i    in   clear sticky error flags
//   rd_data_o    out  byte at FIFO head (0 when empty)
//   rx_valid_o   out  FIFO not empty
//   full_o       out  FIFO full
//   count_o      out  FIFO occupancy
//   frame_err_o  out  sticky: byte dropped on low stop bit
//   overrun_o    out  sticky: byte dropped on full FIFO
//   parity_err_o out  sticky: byte dropped on parity mismatch (0 without parity)
module uart_rx_fifo #(
  parameter int CLKS_PER_BIT = 868,
  parameter int FIFO_DEPTH   = 8
) (
  input  logic                          clk_o,
  input  logic                          reset,
  input  logic                          rx_i,
  input  logic                          rd_en_i,
  input  logic                          clr_err_i,
  output logic [7:0]                    rd_data_o,
  output logic                          rx_valid_o,
  output logic                          full_o,
  output logic [$clog2(FIFO_DEPTH):0]   count_o,
  output logic                          frame_err_o,
  output logic                          overrun_o,
  output logic                          parity_err_o
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF_CNT = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] BIT_CNT  = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef UART_RX_PARITY_EN
    S_PARITY,
`endif
    S_STOP
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [2:0]      idx_q, idx_d;
  logic [7:0]      shift_q, shift_d;
  logic            rx_s1_q, rx_s2_q, rx_prev_q;
  logic            push_req, frame_set, par_set;
  logic            frame_err_q, overrun_q, parity_err_q;
  logic [AW:0]     wr_ptr_q, rd_ptr_q;
  logic [7:0]      mem_q [FIFO_DEPTH];
  logic            empty, full, do_pop, do_push, ovr_set;
`ifdef UART_RX_PARITY_EN
  logic            par_bad_q, par_bad_d;
`endif

  // Synchronizer; rx_prev_q is the previous synchronized value for edge detection
  always_ff @(posedge clk_o) begin
    if (reset) begin
      rx_s1_q   <= 1'b1;
      rx_s2_q   <= 1'b1;
      rx_prev_q <= 1'b1;
    end else begin
      rx_s1_q   <= rx_i;
      rx_s2_q   <= rx_s1_q;
      rx_prev_q <= rx_s2_q;
    end
  end

  // Receiver FSM state
  always_ff @(posedge clk_o) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
`ifdef UART_RX_PARITY_EN
      par_bad_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
`ifdef UART_RX_PARITY_EN
      par_bad_q <= par_bad_d;
`endif
    end
  end

  always_ff @(posedge clk_o) begin
    shift_q <= shift_d;
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    shift_d   = shift_q;
    push_req  = 1'b0;
    frame_set = 1'b0;
    par_set   = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_bad_d = par_bad_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        idx_d = '0;
        if (rx_prev_q && !rx_s2_q) state_d = S_START;
      end
      S_START: begin
        if (cnt_q == HALF_CNT) begin
          cnt_d   = '0;
          // A line already back high mid-start-bit is a glitch
          state_d = rx_s2_q ? S_IDLE : S_DATA;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_DATA: begin
        if (cnt_q == BIT_CNT) begin
          cnt_d   = '0;
          // LSB first: shifting in at the top leaves bit 0 at shift_q[0] after 8 bits
          shift_d = {rx_s2_q, shift_q[7:1]};
          idx_d   = idx_q + 1'b1;
          if (idx_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
            state_d = S_PARITY;
`else
            state_d = S_STOP;
`endif
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
`ifdef UART_RX_PARITY_EN
      S_PARITY: begin
        if (cnt_q == BIT_CNT) begin
          cnt_d     = '0;
          par_bad_d = rx_s2_q ^ (^shift_q);
          state_d   = S_STOP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
`endif
      S_STOP: begin
        if (cnt_q == BIT_CNT) begin
          cnt_d   = '0;
          state_d = S_IDLE;
          if (!rx_s2_q) begin
            frame_set = 1'b1;
`ifdef UART_RX_PARITY_EN
          end else if (par_bad_q) begin
            par_set = 1'b1;
`endif
          end else begin
            push_req = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Receive FIFO; a pop in the same cycle frees a slot for a push into a full FIFO
  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign do_pop  = rd_en_i && !empty;
  assign do_push = push_req && (!full || do_pop);
  assign ovr_set = push_req && full && !do_pop;

  always_ff @(posedge clk_o) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk_o) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= shift_q;
  end

  // Sticky flags: set wins over clear
  always_ff @(posedge clk_o) begin
    if (reset) begin
      frame_err_q  <= 1'b0;
      overrun_q    <= 1'b0;
      parity_err_q <= 1'b0;
    end else begin
      frame_err_q  <= frame_set | (frame_err_q  & ~clr_err_i);
      overrun_q    <= ovr_set   | (overrun_q    & ~clr_err_i);
      parity_err_q <= par_set   | (parity_err_q & ~clr_err_i);
    end
  end

  assign rd_data_o   = empty ? 8'h00 : mem_q[rd_ptr_q[AW-1:0]];
  assign rx_valid_o  = !empty;
  assign full_o      = full;
  assign count_o     = wr_ptr_q - rd_ptr_q;
  assign frame_err_o = frame_err_q;
  assign overrun_o   = overrun_q;
`ifdef UART_RX_PARITY_EN
  assign parity_err_o = parity_err_q;
`else
  assign parity_err_o = 1'b0;
`endif

endmodule
